// File: rtl/vga_tx_pkg.sv
// Shared definitions for the VGA pattern source: default 640x480@60 timing,
// pattern encoding and TinyTapeout VGA-PMOD byte packing.
package vga_tx_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    BARS   = 2'd0,
    CHECK  = 2'd1,
    GRAD   = 2'd2,
    BORDER = 2'd3
  } pattern_e;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOT_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOT_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  function automatic logic [7:0] pack_uo(input logic hs, input logic vs,
                                         input logic [1:0] r, input logic [1:0] g,
                                         input logic [1:0] b);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA source: pixel/line/frame counting plus the
// combinational sync, data-enable and start-of-frame flags for the current pixel.
module vga_timing
  import vga_tx_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic [7:0] frame,
  output logic       de,
  output logic       hs,
  output logic       vs,
  output logic       sof
);

  localparam int         H_TOT    = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int         V_TOT    = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hc_reg, hc_next;
  logic [9:0] vc_reg, vc_next;
  logic [7:0] frame_reg, frame_next;

  always_comb begin
    hc_next    = hc_reg + 10'd1;
    vc_next    = vc_reg;
    frame_next = frame_reg;
    if (hc_reg == H_LAST) begin
      hc_next = '0;
      if (vc_reg == V_LAST) begin
        vc_next    = '0;
        frame_next = frame_reg + 8'd1;
      end else begin
        vc_next = vc_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_reg    <= '0;
      vc_reg    <= '0;
      frame_reg <= '0;
    end else if (en) begin
      hc_reg    <= hc_next;
      vc_reg    <= vc_next;
      frame_reg <= frame_next;
    end
  end

  assign hc    = hc_reg;
  assign vc    = vc_reg;
  assign frame = frame_reg;
  assign de    = (hc_reg < H_ACT) && (vc_reg < V_ACT);
  // vsync spans whole lines, so it depends on the line counter only
  assign hs    = (hc_reg >= HS_FIRST && hc_reg <= HS_LAST) ? HS_POL : ~HS_POL;
  assign vs    = (vc_reg >= VS_FIRST && vc_reg <= VS_LAST) ? VS_POL : ~VS_POL;
  assign sof   = (hc_reg == '0) && (vc_reg == '0);

endmodule

// File: rtl/vga_pattern_tx.sv
// VGA golden-stimulus source: raster timing plus a per-frame selectable test
// pattern, all outputs registered one enabled cycle behind the counters.
module vga_pattern_tx
  import vga_tx_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       en_i,
  input  logic [1:0] pattern_i,
  output logic [1:0] r_o,
  output logic [1:0] g_o,
  output logic [1:0] b_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       de_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic [7:0] frame_o,
  output logic       sof_o,
  output logic [7:0] uo_o
);

  localparam logic [9:0] H_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_END = 10'(V_ACTIVE - 1);

  logic [9:0] hc, vc;
  logic [7:0] frame;
  logic       t_de, t_hs, t_vs, t_sof;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk_i), .rst_n(rst_in), .en(en_i),
    .hc(hc), .vc(vc), .frame(frame),
    .de(t_de), .hs(t_hs), .vs(t_vs), .sof(t_sof)
  );

  // Colour-bar index x/(H_ACTIVE/8) from a thermometer of constant compares
  logic [6:0] bar_ge;
  logic [2:0] bar_idx;

  for (genvar gi = 0; gi < 7; gi++) begin : g_bar
    assign bar_ge[gi] = hc >= 10'((gi + 1) * (H_ACTIVE / 8));
  end

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + 3'(bar_ge[i]);
    end
  end

  pattern_e   pat_reg, pat_cur;
  logic [1:0] r_next, g_next, b_next;

  always_comb begin
    // The selection takes effect on pixel (0,0) itself, then stays for the frame
    pat_cur = t_sof ? pattern_e'(pattern_i) : pat_reg;
    r_next  = '0;
    g_next  = '0;
    b_next  = '0;
    if (t_de) begin
      case (pat_cur)
        BARS: begin
          r_next = {2{bar_idx[2]}};
          g_next = {2{bar_idx[1]}};
          b_next = {2{bar_idx[0]}};
        end
        CHECK: begin
          if (hc[5] ^ vc[5]) {r_next, g_next, b_next} = 6'h3F;
        end
        GRAD: begin
          r_next = hc[8:7];
          g_next = vc[8:7];
          b_next = frame[7:6];
        end
        BORDER: begin
          if (hc == '0 || hc == H_END || vc == '0 || vc == V_END)
            {r_next, g_next, b_next} = 6'h3F;
        end
        default: ;
      endcase
    end
  end

  logic [1:0] r_reg, g_reg, b_reg;
  logic       hs_reg, vs_reg, de_reg, sof_reg;
  logic [9:0] x_reg, y_reg;
  logic [7:0] frame_reg;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      pat_reg   <= BARS;
      r_reg     <= '0;
      g_reg     <= '0;
      b_reg     <= '0;
      hs_reg    <= ~HS_POL;
      vs_reg    <= ~VS_POL;
      de_reg    <= 1'b0;
      sof_reg   <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      frame_reg <= '0;
    end else if (en_i) begin
      pat_reg   <= pat_cur;
      r_reg     <= r_next;
      g_reg     <= g_next;
      b_reg     <= b_next;
      hs_reg    <= t_hs;
      vs_reg    <= t_vs;
      de_reg    <= t_de;
      sof_reg   <= t_sof;
      x_reg     <= hc;
      y_reg     <= vc;
      frame_reg <= frame;
    end
  end

  assign r_o     = r_reg;
  assign g_o     = g_reg;
  assign b_o     = b_reg;
  assign hs_o    = hs_reg;
  assign vs_o    = vs_reg;
  assign de_o    = de_reg;
  assign sof_o   = sof_reg;
  assign x_o     = x_reg;
  assign y_o     = y_reg;
  assign frame_o = frame_reg;
  assign uo_o    = pack_uo(hs_reg, vs_reg, r_reg, g_reg, b_reg);

endmodule

// File: tb/tb_vga_pattern_tx.sv
// Directed bench: instance 0 uses full 640x480 timing, instance 1 a scaled raster
// (80x47), instance 2 a tiny raster (12x5) so frame-count wrap fits in a short run.
module tb_vga_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] pattern;

  logic [1:0] r [3];
  logic [1:0] g [3];
  logic [1:0] b [3];
  logic       hs [3];
  logic       vs [3];
  logic       de [3];
  logic       sof [3];
  logic [9:0] x [3];
  logic [9:0] y [3];
  logic [7:0] frame [3];
  logic [7:0] uo [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  vga_pattern_tx dut0 (
    .clk_i(clk), .rst_in(rst_n), .en_i(en), .pattern_i(pattern),
    .r_o(r[0]), .g_o(g[0]), .b_o(b[0]), .hs_o(hs[0]), .vs_o(vs[0]), .de_o(de[0]),
    .x_o(x[0]), .y_o(y[0]), .frame_o(frame[0]), .sof_o(sof[0]), .uo_o(uo[0])
  );

  vga_pattern_tx #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut1 (
    .clk_i(clk), .rst_in(rst_n), .en_i(en), .pattern_i(pattern),
    .r_o(r[1]), .g_o(g[1]), .b_o(b[1]), .hs_o(hs[1]), .vs_o(vs[1]), .de_o(de[1]),
    .x_o(x[1]), .y_o(y[1]), .frame_o(frame[1]), .sof_o(sof[1]), .uo_o(uo[1])
  );

  vga_pattern_tx #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .clk_i(clk), .rst_in(rst_n), .en_i(en), .pattern_i(pattern),
    .r_o(r[2]), .g_o(g[2]), .b_o(b[2]), .hs_o(hs[2]), .vs_o(vs[2]), .de_o(de[2]),
    .x_o(x[2]), .y_o(y[2]), .frame_o(frame[2]), .sof_o(sof[2]), .uo_o(uo[2])
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // After this, tick number c shows pixel index c-1 of the first frame
  task automatic do_reset(input logic [1:0] pat);
    rst_n   = 1'b0;
    en      = 1'b0;
    pattern = pat;
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    cyc   = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset;
    logic [45:0] got;
    rst_n   = 1'b0;
    en      = 1'b1;
    pattern = 2'd0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      got = {x[i], y[i], frame[i], de[i], sof[i], hs[i], vs[i], r[i], g[i], b[i], uo[i]};
      checks++;
      if (got !== {10'd0, 10'd0, 8'd0, 4'b0011, 6'd0, 8'h88}) begin
        errors++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", i, got,
                 {10'd0, 10'd0, 8'd0, 4'b0011, 6'd0, 8'h88});
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({sof[0], de[0], x[0], y[0], frame[0]} !== {2'b11, 10'd0, 10'd0, 8'd0}) begin
      errors++;
      $display("FAIL first_pixel got sof=%0b de=%0b x=%0d y=%0d frame=%0d exp sof=1 de=1 x=0 y=0 frame=0",
               sof[0], de[0], x[0], y[0], frame[0]);
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hsync;
    int   de_rise = -1, fall1 = -1, fall2 = -1, rise1 = -1;
    logic hs_prev, de_prev;
    do_reset(2'd0);
    hs_prev = hs[0];
    de_prev = de[0];
    for (int k = 0; k < 1700; k++) begin
      tick();
      if (!de_prev && de[0] && de_rise < 0) de_rise = cyc;
      if (hs_prev && !hs[0]) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!hs_prev && hs[0] && fall1 >= 0 && rise1 < 0) rise1 = cyc;
      hs_prev = hs[0];
      de_prev = de[0];
    end
    checks++;
    if (fall2 - fall1 !== 800) begin
      errors++;
      $display("FAIL hs_period got=%0d exp=800", fall2 - fall1);
    end
    checks++;
    if (rise1 - fall1 !== 96) begin
      errors++;
      $display("FAIL hs_width got=%0d exp=96", rise1 - fall1);
    end
    checks++;
    if (fall1 - de_rise !== 656) begin
      errors++;
      $display("FAIL hs_offset got=%0d exp=656", fall1 - de_rise);
    end
    $display("test_hsync de_rise=%0d fall1=%0d fall2=%0d rise1=%0d", de_rise, fall1, fall2, rise1);
  endtask

  // Continues the full-timing raster from test_hsync
  task automatic test_bars;
    run_to(8081);
    checks++;
    if ({x[0], y[0], de[0], r[0], g[0], b[0], uo[0]} !== {10'd80, 10'd10, 7'b1_00_00_11, 8'hCC}) begin
      errors++;
      $display("FAIL bars_80_10 got x=%0d y=%0d de=%0b rgb=%0d%0d%0d uo=%h exp x=80 y=10 de=1 rgb=003 uo=cc",
               x[0], y[0], de[0], r[0], g[0], b[0], uo[0]);
    end
    run_to(8161);
    checks++;
    if ({x[0], de[0], r[0], g[0], b[0]} !== {10'd160, 7'b1_00_11_00}) begin
      errors++;
      $display("FAIL bars_160 got x=%0d de=%0b rgb=%0d%0d%0d exp x=160 de=1 rgb=030",
               x[0], de[0], r[0], g[0], b[0]);
    end
    run_to(8640);
    checks++;
    if ({x[0], de[0], r[0], g[0], b[0], uo[0]} !== {10'd639, 7'b1_11_11_11, 8'hFF}) begin
      errors++;
      $display("FAIL bars_639 got x=%0d de=%0b rgb=%0d%0d%0d uo=%h exp x=639 de=1 rgb=333 uo=ff",
               x[0], de[0], r[0], g[0], b[0], uo[0]);
    end
    run_to(8641);
    checks++;
    if ({x[0], de[0], r[0], g[0], b[0], uo[0]} !== {10'd640, 7'b0, 8'h88}) begin
      errors++;
      $display("FAIL bars_640_blank got x=%0d de=%0b rgb=%0d%0d%0d uo=%h exp x=640 de=0 rgb=000 uo=88",
               x[0], de[0], r[0], g[0], b[0], uo[0]);
    end
    run_to(8661);
    checks++;
    if ({x[0], hs[0], uo[0]} !== {10'd660, 1'b0, 8'h08}) begin
      errors++;
      $display("FAIL hsync_uo got x=%0d hs=%0b uo=%h exp x=660 hs=0 uo=08", x[0], hs[0], uo[0]);
    end
    $display("test_bars done checks=%0d errors=%0d", checks, errors);
  endtask

  // Scaled raster: 80 clocks/line, 47 lines, vsync on lines 42..43, 3760 clocks/frame
  task automatic test_frames;
    int   vs_low = 0, sof_cnt = 0, sof_first = -1, sof_second = -1;
    int   vs_falls = 0, hs_since_vs = 0, hs_per_vs = -1;
    logic [7:0] f_a = 8'hxx, f_b = 8'hxx, f_c = 8'hxx;
    logic hs_prev, vs_prev;
    do_reset(2'd0);
    hs_prev = hs[1];
    vs_prev = vs[1];
    for (int k = 0; k < 7600; k++) begin
      tick();
      if (!vs[1]) vs_low++;
      if (sof[1]) begin
        sof_cnt++;
        if (sof_first < 0) sof_first = cyc;
        else if (sof_second < 0) sof_second = cyc;
      end
      if (hs_prev && !hs[1]) hs_since_vs++;
      if (vs_prev && !vs[1]) begin
        vs_falls++;
        if (vs_falls == 2) hs_per_vs = hs_since_vs;
        hs_since_vs = 0;
      end
      if (cyc == 3760) f_a = frame[1];
      if (cyc == 3761) f_b = frame[1];
      if (cyc == 7521) f_c = frame[1];
      hs_prev = hs[1];
      vs_prev = vs[1];
    end
    checks++;
    if (hs_per_vs !== 47) begin
      errors++;
      $display("FAIL hs_per_vs got=%0d exp=47", hs_per_vs);
    end
    checks++;
    if (vs_low !== 320) begin
      errors++;
      $display("FAIL vs_low_cycles got=%0d exp=320", vs_low);
    end
    checks++;
    if (sof_cnt !== 3 || sof_second - sof_first !== 3760) begin
      errors++;
      $display("FAIL sof_rate got count=%0d gap=%0d exp count=3 gap=3760", sof_cnt, sof_second - sof_first);
    end
    checks++;
    if ({f_a, f_b, f_c} !== {8'd0, 8'd1, 8'd2}) begin
      errors++;
      $display("FAIL frame_count got %0d,%0d,%0d exp 0,1,2", f_a, f_b, f_c);
    end
    $display("test_frames sof_cnt=%0d vs_low=%0d hs_per_vs=%0d", sof_cnt, vs_low, hs_per_vs);
  endtask

  task automatic test_pattern_switch;
    do_reset(2'd0);
    run_to(801);
    pattern = 2'd1;
    run_to(1609);
    checks++;
    if ({x[1], y[1], de[1], r[1], g[1], b[1]} !== {10'd8, 10'd20, 7'b1_00_00_11}) begin
      errors++;
      $display("FAIL switch_bars_hold got x=%0d y=%0d de=%0b rgb=%0d%0d%0d exp x=8 y=20 de=1 rgb=003",
               x[1], y[1], de[1], r[1], g[1], b[1]);
    end
    run_to(3761);
    checks++;
    if ({sof[1], de[1], r[1], g[1], b[1]} !== {2'b11, 6'd0}) begin
      errors++;
      $display("FAIL checker_0_0 got sof=%0b de=%0b rgb=%0d%0d%0d exp sof=1 de=1 rgb=000",
               sof[1], de[1], r[1], g[1], b[1]);
    end
    run_to(3793);
    checks++;
    if ({x[1], y[1], r[1], g[1], b[1]} !== {10'd32, 10'd0, 6'h3F}) begin
      errors++;
      $display("FAIL checker_32_0 got x=%0d y=%0d rgb=%0d%0d%0d exp x=32 y=0 rgb=333",
               x[1], y[1], r[1], g[1], b[1]);
    end
    run_to(6321);
    checks++;
    if ({x[1], y[1], r[1], g[1], b[1]} !== {10'd0, 10'd32, 6'h3F}) begin
      errors++;
      $display("FAIL checker_0_32 got x=%0d y=%0d rgb=%0d%0d%0d exp x=0 y=32 rgb=333",
               x[1], y[1], r[1], g[1], b[1]);
    end
    run_to(6353);
    checks++;
    if ({x[1], y[1], de[1], r[1], g[1], b[1]} !== {10'd32, 10'd32, 7'b1_00_00_00}) begin
      errors++;
      $display("FAIL checker_32_32 got x=%0d y=%0d de=%0b rgb=%0d%0d%0d exp x=32 y=32 de=1 rgb=000",
               x[1], y[1], de[1], r[1], g[1], b[1]);
    end
    $display("test_pattern_switch done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_border;
    int         c_tab [6] = '{1, 401, 406, 464, 3046, 3126};
    logic [5:0] e_tab [6] = '{6'h3F, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F};
    do_reset(2'd3);
    for (int i = 0; i < 6; i++) begin
      run_to(c_tab[i]);
      checks++;
      if ({de[1], r[1], g[1], b[1]} !== {1'b1, e_tab[i]}) begin
        errors++;
        $display("FAIL border x=%0d y=%0d got de=%0b rgb=%h exp de=1 rgb=%h",
                 x[1], y[1], de[1], {r[1], g[1], b[1]}, e_tab[i]);
      end
    end
    $display("test_border done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_enable;
    logic [45:0] snap, cur;
    int   hold_bad = 0, fall1 = -1, fall2 = -1;
    logic hs_prev;
    do_reset(2'd0);
    hs_prev = hs[0];
    for (int k = 0; k < 3200; k++) begin
      en   = (k % 2 == 0);
      snap = {x[0], y[0], frame[0], de[0], sof[0], hs[0], vs[0], r[0], g[0], b[0], uo[0]};
      tick();
      cur  = {x[0], y[0], frame[0], de[0], sof[0], hs[0], vs[0], r[0], g[0], b[0], uo[0]};
      if (!en && cur !== snap) hold_bad++;
      if (hs_prev && !hs[0]) begin
        if (fall1 < 0) fall1 = k;
        else if (fall2 < 0) fall2 = k;
      end
      hs_prev = hs[0];
    end
    en = 1'b1;
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL enable_hold got changes=%0d exp=0", hold_bad);
    end
    checks++;
    if (fall2 - fall1 !== 1600) begin
      errors++;
      $display("FAIL enable_line_period got=%0d exp=1600", fall2 - fall1);
    end
    checks++;
    if ({x[0], y[0]} !== {10'd799, 10'd1}) begin
      errors++;
      $display("FAIL enable_progress got x=%0d y=%0d exp x=799 y=1", x[0], y[0]);
    end
    $display("test_enable hold_bad=%0d period=%0d", hold_bad, fall2 - fall1);
  endtask

  task automatic test_async_reset;
    logic [45:0] got;
    do_reset(2'd0);
    run_to(1630);
    checks++;
    if ({x[1], y[1], de[1]} !== {10'd29, 10'd20, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_pos got x=%0d y=%0d de=%0b exp x=29 y=20 de=1", x[1], y[1], de[1]);
    end
    rst_n = 1'b0;
    #2;
    got = {x[1], y[1], frame[1], de[1], sof[1], hs[1], vs[1], r[1], g[1], b[1], uo[1]};
    checks++;
    if (got !== {10'd0, 10'd0, 8'd0, 4'b0011, 6'd0, 8'h88}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got, {10'd0, 10'd0, 8'd0, 4'b0011, 6'd0, 8'h88});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({sof[1], de[1], x[1], y[1], frame[1]} !== {2'b11, 10'd0, 10'd0, 8'd0}) begin
      errors++;
      $display("FAIL post_reset_pixel got sof=%0b de=%0b x=%0d y=%0d frame=%0d exp sof=1 de=1 x=0 y=0 frame=0",
               sof[1], de[1], x[1], y[1], frame[1]);
    end
    $display("test_async_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  // Tiny raster: 12 clocks/line, 5 lines, 60 clocks/frame; gradient blue = frame[7:6]
  task automatic test_frame_wrap;
    do_reset(2'd2);
    run_to(100 * 60 + 1);
    checks++;
    if ({frame[2], de[2], r[2], g[2], b[2]} !== {8'd100, 7'b1_00_00_01}) begin
      errors++;
      $display("FAIL grad_frame100 got frame=%0d de=%0b rgb=%0d%0d%0d exp frame=100 de=1 rgb=001",
               frame[2], de[2], r[2], g[2], b[2]);
    end
    run_to(200 * 60 + 1);
    checks++;
    if ({frame[2], de[2], r[2], g[2], b[2]} !== {8'd200, 7'b1_00_00_11}) begin
      errors++;
      $display("FAIL grad_frame200 got frame=%0d de=%0b rgb=%0d%0d%0d exp frame=200 de=1 rgb=003",
               frame[2], de[2], r[2], g[2], b[2]);
    end
    run_to(256 * 60);
    checks++;
    if (frame[2] !== 8'd255) begin
      errors++;
      $display("FAIL frame_255 got=%0d exp=255", frame[2]);
    end
    run_to(256 * 60 + 1);
    checks++;
    if ({frame[2], sof[2]} !== {8'd0, 1'b1}) begin
      errors++;
      $display("FAIL frame_wrap got frame=%0d sof=%0b exp frame=0 sof=1", frame[2], sof[2]);
    end
    $display("test_frame_wrap done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    pattern = 2'd0;
    test_reset();
    test_hsync();
    test_bars();
    test_frames();
    test_pattern_switch();
    test_border();
    test_enable();
    test_async_reset();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
